pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of the PC and all address ports.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded by reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100, PC value loaded on trap or misaligned redirect.
REQ-004 Parameter IALIGN, default 4, legal values 2 or 4; sets the sequential increment and the alignment check.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 stall_i  in  1  pipeline stall; blocks sequential advance.
REQ-008 halt_i  in  1  request to halt fetch.
REQ-009 redirect_valid_i  in  1  branch/jump redirect strobe.
REQ-010 redirect_target_i  in  XLEN  redirect destination.
REQ-011 trap_i  in  1  trap strobe.
REQ-012 mret_i  in  1  return-from-trap strobe.
REQ-013 mepc_i  in  XLEN  return address used by mret_i.
REQ-014 fetch_ready_i  in  1  instruction memory accepts the address.
REQ-015 fetch_valid_o  out  1  pc_o is a valid fetch request.
REQ-016 pc_o  out  XLEN  current fetch PC, registered.
REQ-017 misalign_o  out  1  one-cycle pulse on a rejected misaligned redirect.
REQ-018 misalign_addr_o  out  XLEN  offending target, latched; held until the next misalignment event.
REQ-019 state_o  out  2  current FSM state encoding.

Function
REQ-020 States SHALL be BOOT=0, FETCH=1, STALL=2, HALTED=3; fetch_valid_o SHALL be 1 exactly when the state is FETCH.
REQ-021 BOOT SHALL move to FETCH unconditionally one cycle after rst deasserts, with pc_o unchanged.
REQ-022 A handshake is fetch_valid_o & fetch_ready_i; on a handshake with no control event, pc_o SHALL advance by IALIGN, modulo 2^XLEN (all-ones wraps to 0 with no flag).
REQ-023 Without a handshake or control event, pc_o SHALL hold, so the address stays stable while fetch_valid_o is 1.
REQ-024 Priority per cycle SHALL be trap_i > mret_i > redirect_valid_i > halt_i > stall_i > sequential advance.
REQ-025 trap_i SHALL load TRAP_VEC and go to FETCH from any non-BOOT state, regardless of stall or handshake.
REQ-026 mret_i SHALL load mepc_i with bit 0 (IALIGN=2) or bits 1:0 (IALIGN=4) forced to zero, and go to FETCH.
REQ-027 An aligned redirect SHALL load redirect_target_i and go to FETCH; a handshake in the same cycle is consumed, but the increment is discarded.
REQ-028 A redirect with target mod IALIGN != 0 SHALL NOT be taken; instead pc_o SHALL load TRAP_VEC, misalign_o SHALL pulse for one cycle, misalign_addr_o SHALL capture the target, and the state SHALL become FETCH.
REQ-029 FETCH with stall_i=1 SHALL go to STALL; if a handshake also occurs that cycle, pc_o SHALL still advance by IALIGN.
REQ-030 STALL SHALL return to FETCH in the cycle after stall_i=0, with pc_o held throughout.
REQ-031 halt_i in FETCH or STALL SHALL go to HALTED, holding pc_o; HALTED SHALL exit only on trap_i, mret_i or redirect_valid_i.
REQ-032 Control strobes arriving in BOOT SHALL be ignored.

Reset
REQ-033 While rst=1: pc_o=RESET_VEC, state=BOOT, fetch_valid_o=0, misalign_o=0, misalign_addr_o=0.
REQ-034 rst asserted mid-operation SHALL apply REQ-033 immediately and asynchronously, abandoning any in-flight request.

Structure
REQ-035 Package pc_gen_pkg SHALL hold the state enum and the IALIGN legal-value check.
REQ-036 One combinational sub-module, pc_next_sel, SHALL implement the priority mux and alignment check; pc_gen holds only the registers and the FSM.

Verification
REQ-037 Reset release with fetch_ready_i=1 -> pc_o 0x0, 0x0 (BOOT), then 0x0, 0x4, 0x8 on successive cycles.
REQ-038 FETCH with fetch_ready_i=0 for 3 cycles at pc_o=0x40 -> pc_o stays 0x40 and fetch_valid_o stays 1.
REQ-039 Redirect to 0x200 together with stall_i=1 and a handshake -> next pc_o=0x200, state FETCH.
REQ-040 IALIGN=4, redirect to 0x102 -> pc_o=0x100, misalign_o=1 for one cycle, misalign_addr_o=0x102.
REQ-041 trap_i, redirect_valid_i and mret_i all asserted in one cycle -> pc_o=TRAP_VEC; later mret_i with mepc_i=0x87 -> pc_o=0x84.
REQ-042 XLEN=16, pc_o=0xFFFC with a handshake -> pc_o=0x0000; rst pulse in STALL -> pc_o=RESET_VEC, state BOOT.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and elaboration helpers for the fetch PC generator.
package pc_gen_pkg;

    // FSM state encoding, visible on state_o.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STALL  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // Winning control event for a cycle, already resolved by priority.
    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_STALL    = 3'd1,
        EV_HALT     = 3'd2,
        EV_REDIRECT = 3'd3,
        EV_MISALIGN = 3'd4,
        EV_MRET     = 3'd5,
        EV_TRAP     = 3'd6
    } event_t;

    // Only 16-bit and 32-bit instruction alignment are supported.
    function automatic bit ialign_legal(input int unsigned ialign);
        return (ialign == 32'd2) || (ialign == 32'd4);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control and fetch-request bundle between the core and the PC generator.
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall_i;
    logic            halt_i;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_target_i;
    logic            trap_i;
    logic            mret_i;
    logic [XLEN-1:0] mepc_i;
    logic            fetch_ready_i;
    logic            fetch_valid_o;
    logic [XLEN-1:0] pc_o;
    logic            misalign_o;
    logic [XLEN-1:0] misalign_addr_o;
    logic [1:0]      state_o;

    // PC generator side: consumes control, produces the fetch request.
    modport master (
        input  stall_i, halt_i, redirect_valid_i, redirect_target_i,
        input  trap_i, mret_i, mepc_i, fetch_ready_i,
        output fetch_valid_o, pc_o, misalign_o, misalign_addr_o, state_o
    );

    // Core / instruction memory side.
    modport slave (
        output stall_i, halt_i, redirect_valid_i, redirect_target_i,
        output trap_i, mret_i, mepc_i, fetch_ready_i,
        input  fetch_valid_o, pc_o, misalign_o, misalign_addr_o, state_o
    );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational priority mux: picks the winning control event and next PC.
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     IALIGN   = 4,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
    input  state_t          state,
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc_next_c,
    output event_t          ev_c
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 32'd1);
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(IALIGN);

    logic            handshake;
    logic            misaligned;
    logic [XLEN-1:0] pc_seq;

    // Priority: trap > mret > redirect > halt > stall > sequential; BOOT ignores all.
    always_comb begin
        handshake  = (state == ST_FETCH) && fetch_ready;
        misaligned = |(redirect_target & ALIGN_MASK);
        pc_seq     = handshake ? (pc + PC_INC) : pc;
        pc_next_c  = pc;
        ev_c       = EV_NONE;
        if (state != ST_BOOT) begin
            if (trap) begin
                ev_c      = EV_TRAP;
                pc_next_c = TRAP_VEC;
            end else if (mret) begin
                ev_c      = EV_MRET;
                pc_next_c = mepc & ~ALIGN_MASK;
            end else if (redirect_valid) begin
                if (misaligned) begin
                    ev_c      = EV_MISALIGN;
                    pc_next_c = TRAP_VEC;
                end else begin
                    // A same-cycle handshake is consumed; its increment is dropped.
                    ev_c      = EV_REDIRECT;
                    pc_next_c = redirect_target;
                end
            end else if (halt) begin
                ev_c      = EV_HALT;
                pc_next_c = pc;
            end else if (stall) begin
                // The request accepted in the stalling cycle still counts.
                ev_c      = EV_STALL;
                pc_next_c = pc_seq;
            end else begin
                ev_c      = EV_NONE;
                pc_next_c = pc_seq;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: PC/status registers and the fetch FSM.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int unsigned     IALIGN    = 4
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);

    // Reject unsupported alignment at elaboration.
    if (!ialign_legal(IALIGN)) begin : g_ialign_check
        $error("pc_gen: IALIGN must be 2 or 4");
    end

    state_t          state_q;
    state_t          state_d;
    event_t          ev;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            fetch_valid_q;
    logic            misalign_q;
    logic [XLEN-1:0] misalign_addr_q;

    pc_next_sel #(
        .XLEN     (XLEN),
        .IALIGN   (IALIGN),
        .TRAP_VEC (TRAP_VEC)
    ) u_sel (
        .state           (state_q),
        .pc              (pc_q),
        .stall           (bus.stall_i),
        .halt            (bus.halt_i),
        .redirect_valid  (bus.redirect_valid_i),
        .redirect_target (bus.redirect_target_i),
        .trap            (bus.trap_i),
        .mret            (bus.mret_i),
        .mepc            (bus.mepc_i),
        .fetch_ready     (bus.fetch_ready_i),
        .pc_next_c       (pc_d),
        .ev_c            (ev)
    );

    // Next-state logic driven by the resolved control event.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            default: begin
                case (ev)
                    EV_TRAP, EV_MRET, EV_REDIRECT, EV_MISALIGN: state_d = ST_FETCH;
                    EV_HALT:  state_d = ST_HALTED;
                    EV_STALL: state_d = (state_q == ST_FETCH) ? ST_STALL : state_q;
                    default:  state_d = (state_q == ST_STALL) ? ST_FETCH : state_q;
                endcase
            end
        endcase
    end

    // State, PC and status registers; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_VEC;
            fetch_valid_q   <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= (state_d == ST_FETCH);
            misalign_q    <= (ev == EV_MISALIGN);
            if (ev == EV_MISALIGN) begin
                misalign_addr_q <= bus.redirect_target_i;
            end
        end
    end

    assign bus.pc_o            = pc_q;
    assign bus.state_o         = state_q;
    assign bus.fetch_valid_o   = fetch_valid_q;
    assign bus.misalign_o      = misalign_q;
    assign bus.misalign_addr_o = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: 32-bit and 16-bit instances, vector table plus scoreboard.
module tb_pc_gen;

    logic clk = 1'b0;
    logic rst32;
    logic rst16;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32)) if32 ();
    pc_gen_if #(.XLEN(16)) if16 ();

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100),
        .IALIGN    (4)
    ) u_dut32 (
        .clk (clk),
        .rst (rst32),
        .bus (if32)
    );

    pc_gen #(
        .XLEN      (16),
        .RESET_VEC (16'h0000),
        .TRAP_VEC  (16'h0100),
        .IALIGN    (4)
    ) u_dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (if16)
    );

    typedef struct {
        string       name;
        int          which;   // 0: 32-bit instance, 1: 16-bit instance
        logic        stall;
        logic        halt;
        logic        rv;
        logic [31:0] tgt;
        logic        trap;
        logic        mret;
        logic [31:0] mepc;
        logic        rdy;
        logic [31:0] e_pc;
        logic [1:0]  e_st;
        logic        e_mis;
        logic [31:0] e_maddr;
    } vec_t;

    typedef struct {
        string       name;
        int          which;
        logic [31:0] pc;
        logic [1:0]  st;
        logic        mis;
        logic [31:0] maddr;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(string n, int w, logic st, logic hl, logic rv,
                                logic [31:0] tg, logic tr, logic mr, logic [31:0] me,
                                logic rd, logic [31:0] epc, logic [1:0] es,
                                logic em, logic [31:0] ema);
        vec_t v;
        v.name = n;   v.which = w;  v.stall = st; v.halt = hl; v.rv = rv;
        v.tgt  = tg;  v.trap = tr;  v.mret = mr;  v.mepc = me; v.rdy = rd;
        v.e_pc = epc; v.e_st = es;  v.e_mis = em; v.e_maddr = ema;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        if32.stall_i = 1'b0; if32.halt_i = 1'b0; if32.redirect_valid_i = 1'b0;
        if32.redirect_target_i = '0; if32.trap_i = 1'b0; if32.mret_i = 1'b0;
        if32.mepc_i = '0; if32.fetch_ready_i = 1'b0;
        if16.stall_i = 1'b0; if16.halt_i = 1'b0; if16.redirect_valid_i = 1'b0;
        if16.redirect_target_i = '0; if16.trap_i = 1'b0; if16.mret_i = 1'b0;
        if16.mepc_i = '0; if16.fetch_ready_i = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        if (v.which == 0) begin
            if32.stall_i = v.stall; if32.halt_i = v.halt; if32.redirect_valid_i = v.rv;
            if32.redirect_target_i = v.tgt; if32.trap_i = v.trap; if32.mret_i = v.mret;
            if32.mepc_i = v.mepc; if32.fetch_ready_i = v.rdy;
        end else begin
            if16.stall_i = v.stall; if16.halt_i = v.halt; if16.redirect_valid_i = v.rv;
            if16.redirect_target_i = 16'(v.tgt); if16.trap_i = v.trap; if16.mret_i = v.mret;
            if16.mepc_i = 16'(v.mepc); if16.fetch_ready_i = v.rdy;
        end
    endtask

    task automatic compare_out();
        exp_t        e;
        logic [31:0] a_pc;
        logic [31:0] a_maddr;
        logic [1:0]  a_st;
        logic        a_valid;
        logic        a_mis;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        if (e.which == 0) begin
            a_pc = if32.pc_o; a_st = if32.state_o; a_valid = if32.fetch_valid_o;
            a_mis = if32.misalign_o; a_maddr = if32.misalign_addr_o;
        end else begin
            a_pc = 32'(if16.pc_o); a_st = if16.state_o; a_valid = if16.fetch_valid_o;
            a_mis = if16.misalign_o; a_maddr = 32'(if16.misalign_addr_o);
        end
        check({e.name, ".pc"},            a_pc,           e.pc);
        check({e.name, ".state"},         32'(a_st),      32'(e.st));
        check({e.name, ".fetch_valid"},   32'(a_valid),   32'(e.st == 2'd1));
        check({e.name, ".misalign"},      32'(a_mis),     32'(e.mis));
        check({e.name, ".misalign_addr"}, a_maddr,        e.maddr);
    endtask

    // Apply one vector at the falling edge, compare just after the rising edge.
    task automatic step(input vec_t v);
        exp_t e;
        drive_idle();
        drive(v);
        e.name = v.name; e.which = v.which; e.pc = v.e_pc;
        e.st = v.e_st; e.mis = v.e_mis; e.maddr = v.e_maddr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
        @(negedge clk);
    endtask

    task automatic check_reset(input int which, input string tag);
        if (which == 0) begin
            check({tag, ".pc"},            if32.pc_o,               32'h0);
            check({tag, ".state"},         32'(if32.state_o),       32'd0);
            check({tag, ".fetch_valid"},   32'(if32.fetch_valid_o), 32'd0);
            check({tag, ".misalign"},      32'(if32.misalign_o),    32'd0);
            check({tag, ".misalign_addr"}, if32.misalign_addr_o,    32'h0);
        end else begin
            check({tag, ".pc"},            32'(if16.pc_o),            32'h0);
            check({tag, ".state"},         32'(if16.state_o),         32'd0);
            check({tag, ".fetch_valid"},   32'(if16.fetch_valid_o),   32'd0);
            check({tag, ".misalign"},      32'(if16.misalign_o),      32'd0);
            check({tag, ".misalign_addr"}, 32'(if16.misalign_addr_o), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        rst32 = 1'b1;
        rst16 = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check_reset(0, "reset32");
        check_reset(1, "reset16");

        //           name        w  st hl rv tgt            tr mr mepc           rd  e_pc           st    mis maddr
        tbl.push_back(mk("boot_ign",  0, 0, 0, 1, 32'h0000_0102, 1, 0, 32'h0,         1, 32'h0000_0000, 2'd1, 0, 32'h0));
        tbl.push_back(mk("seq4",      0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0004, 2'd1, 0, 32'h0));
        tbl.push_back(mk("seq8",      0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0008, 2'd1, 0, 32'h0));
        tbl.push_back(mk("redir40",   0, 0, 0, 1, 32'h0000_0040, 0, 0, 32'h0,         0, 32'h0000_0040, 2'd1, 0, 32'h0));
        tbl.push_back(mk("hold1",     0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0040, 2'd1, 0, 32'h0));
        tbl.push_back(mk("hold2",     0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0040, 2'd1, 0, 32'h0));
        tbl.push_back(mk("hold3",     0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0040, 2'd1, 0, 32'h0));
        tbl.push_back(mk("stall_hs",  0, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0044, 2'd2, 0, 32'h0));
        tbl.push_back(mk("stall_hld", 0, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0044, 2'd2, 0, 32'h0));
        tbl.push_back(mk("unstall",   0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0044, 2'd1, 0, 32'h0));
        tbl.push_back(mk("seq48",     0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0048, 2'd1, 0, 32'h0));
        tbl.push_back(mk("redir_stl", 0, 1, 0, 1, 32'h0000_0200, 0, 0, 32'h0,         1, 32'h0000_0200, 2'd1, 0, 32'h0));
        tbl.push_back(mk("misalign",  0, 0, 0, 1, 32'h0000_0102, 0, 0, 32'h0,         0, 32'h0000_0100, 2'd1, 1, 32'h0000_0102));
        tbl.push_back(mk("mis_pulse", 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0100, 2'd1, 0, 32'h0000_0102));
        tbl.push_back(mk("halt",      0, 0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0100, 2'd3, 0, 32'h0000_0102));
        tbl.push_back(mk("halt_stl",  0, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0100, 2'd3, 0, 32'h0000_0102));
        tbl.push_back(mk("halt_hld",  0, 0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0100, 2'd3, 0, 32'h0000_0102));
        tbl.push_back(mk("halt_rdir", 0, 0, 0, 1, 32'h0000_0600, 0, 0, 32'h0,         0, 32'h0000_0600, 2'd1, 0, 32'h0000_0102));
        tbl.push_back(mk("trap_all",  0, 0, 0, 1, 32'h0000_0302, 1, 1, 32'h0000_0500, 1, 32'h0000_0100, 2'd1, 0, 32'h0000_0102));
        tbl.push_back(mk("seq104",    0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0104, 2'd1, 0, 32'h0000_0102));
        tbl.push_back(mk("mret87",    0, 0, 0, 0, 32'h0,         0, 1, 32'h0000_0087, 1, 32'h0000_0084, 2'd1, 0, 32'h0000_0102));
        tbl.push_back(mk("stall84",   0, 1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0084, 2'd2, 0, 32'h0000_0102));
        tbl.push_back(mk("halt_in_s", 0, 1, 1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0084, 2'd3, 0, 32'h0000_0102));
        tbl.push_back(mk("halt_rdy",  0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0084, 2'd3, 0, 32'h0000_0102));
        tbl.push_back(mk("halt_trap", 0, 0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_0100, 2'd1, 0, 32'h0000_0102));
        tbl.push_back(mk("mret_pri",  0, 0, 0, 1, 32'h0000_0008, 0, 1, 32'h1000_0003, 1, 32'h1000_0000, 2'd1, 0, 32'h0000_0102));
        tbl.push_back(mk("redir_top", 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 2'd1, 0, 32'h0000_0102));
        tbl.push_back(mk("wrap32",    0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 2'd1, 0, 32'h0000_0102));
        tbl.push_back(mk("mis_halt",  0, 0, 1, 1, 32'h0000_0003, 0, 0, 32'h0,         0, 32'h0000_0100, 2'd1, 1, 32'h0000_0003));
        tbl.push_back(mk("to_stall",  0, 1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0100, 2'd2, 0, 32'h0000_0003));

        tbl.push_back(mk("d16_boot",  1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0000, 2'd1, 0, 32'h0));
        tbl.push_back(mk("d16_mis",   1, 0, 0, 1, 32'h0000_0102, 0, 0, 32'h0,         0, 32'h0000_0100, 2'd1, 1, 32'h0000_0102));
        tbl.push_back(mk("d16_top",   1, 0, 0, 1, 32'h0000_FFFC, 0, 0, 32'h0,         0, 32'h0000_FFFC, 2'd1, 0, 32'h0000_0102));
        tbl.push_back(mk("d16_wrap",  1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 2'd1, 0, 32'h0000_0102));
        tbl.push_back(mk("d16_stall", 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0004, 2'd2, 0, 32'h0000_0102));

        @(negedge clk);
        rst32 = 1'b0;
        foreach (tbl[i]) begin
            if (tbl[i].which == 0) step(tbl[i]);
        end

        // Asynchronous reset in STALL, observed before the next clock edge.
        #2 rst32 = 1'b1;
        #1 check_reset(0, "async_rst32");

        @(negedge clk);
        rst16 = 1'b0;
        foreach (tbl[i]) begin
            if (tbl[i].which == 1) step(tbl[i]);
        end

        #2 rst16 = 1'b1;
        #1 check_reset(1, "async_rst16");

        @(posedge clk);
        #1 check_reset(1, "rst16_held");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
